// File: rtl/serial_word_tx_pkg.sv
// Shared types and line levels for the serial word transmitter.
package serial_word_tx_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Line levels for the framing bits.
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_rate_divider.sv
// Bit-period divider: counts 0..Div-1 while enabled and flags the last cycle of each bit.
module serial_word_tx_bit_rate_divider
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned Div = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned     CntW   = cnt_width(Div);
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at CntMax while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The edge ending this cycle is a bit boundary.
  assign tick_o = en_i && !clear_i && (cnt_q == CntMax);

endmodule

// File: rtl/serial_word_tx.sv
// Serial word transmitter: start bit, LSB-first data, optional even parity, stop bit.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD,
  output logic             READY,
  output logic             SDO,
  output logic             SDOn,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned    BcW   = cnt_width(WIDTH);
  localparam logic [BcW-1:0] BcMax = BcW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_nxt;
  logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             parity_q, parity_d;
  logic             sdo_q, sdo_d;
  logic             sdon_q;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             bit_tick;

  assign accept    = (state_q == StIdle) && LOAD;
  assign shift_nxt = shift_q >> 1;

  serial_word_tx_bit_rate_divider #(
    .Div (DIV)
  ) u_bit_rate_divider (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .clear_i (accept),
    .en_i    (state_q != StIdle),
    .tick_o  (bit_tick)
  );

  // Frame sequencing and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    sdo_d     = sdo_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        sdo_d   = IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (LOAD) begin
          shift_d   = DATA;
          parity_d  = ^DATA;
          bit_cnt_d = '0;
          state_d   = StStart;
          sdo_d     = START_LEVEL;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d   = StData;
          sdo_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = shift_nxt;
          if (bit_cnt_q == BcMax) begin
            if (PARITY_EN) begin
              state_d = StParity;
              sdo_d   = parity_q;
            end else begin
              state_d = StStop;
              sdo_d   = STOP_LEVEL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sdo_d     = shift_nxt[0];
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
          sdo_d   = STOP_LEVEL;
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d = StIdle;
          sdo_d   = IDLE_LEVEL;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        sdo_d   = IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; SDOn is taken from the same next value as SDO.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      sdo_q     <= IDLE_LEVEL;
      sdon_q    <= ~IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      sdo_q     <= sdo_d;
      sdon_q    <= ~sdo_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign READY = ready_q;
  assign SDO   = sdo_q;
  assign SDOn  = sdon_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx across three parameter sets.
module tb_serial_word_tx;

  typedef struct {
    logic [15:0] bits;   // line level per bit slot, slot 0 first on the line
    int          nbits;
    int          div;
    int          start;  // edge index at which the start bit must appear
  } frame_t;

  logic       clk;
  logic [2:0] rstn;
  logic [2:0] load;
  logic [7:0] data0, data1, data2;
  logic [2:0] ready, sdo, sdon, busy, done;

  int cyc;
  int total;
  int bad;
  int next_ok [3];
  frame_t q0[$], q1[$], q2[$];

  serial_word_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1'b1)) u_dut0 (
    .CLK(clk), .RSTn(rstn[0]), .DATA(data0), .LOAD(load[0]), .READY(ready[0]),
    .SDO(sdo[0]), .SDOn(sdon[0]), .BUSY(busy[0]), .DONE(done[0])
  );
  serial_word_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1'b0)) u_dut1 (
    .CLK(clk), .RSTn(rstn[1]), .DATA(data1), .LOAD(load[1]), .READY(ready[1]),
    .SDO(sdo[1]), .SDOn(sdon[1]), .BUSY(busy[1]), .DONE(done[1])
  );
  serial_word_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(1'b1)) u_dut2 (
    .CLK(clk), .RSTn(rstn[2]), .DATA(data2), .LOAD(load[2]), .READY(ready[2]),
    .SDO(sdo[2]), .SDOn(sdon[2]), .BUSY(busy[2]), .DONE(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return (2 + 8 + par_of(k)) * div_of(k);
  endfunction

  function automatic logic [7:0] data_of(input int k);
    if (k == 0) return data0;
    if (k == 1) return data1;
    return data2;
  endfunction

  function automatic int qsize(input int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic qpush(input int k, input frame_t f);
    if (k == 0) q0.push_back(f);
    else if (k == 1) q1.push_back(f);
    else q2.push_back(f);
  endtask

  task automatic qpop(input int k, output frame_t f);
    if (k == 0) f = q0.pop_front();
    else if (k == 1) f = q1.pop_front();
    else f = q2.pop_front();
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete();
    else if (k == 1) q1.delete();
    else q2.delete();
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  // Expected frame built straight from the framing rules.
  task automatic model_accept(input int k, input logic [7:0] d, input int e);
    frame_t f;
    int     idx;
    f.bits    = '0;
    f.bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) f.bits[1+j] = d[j];
    idx = 9;
    if (par_of(k) != 0) begin
      f.bits[9] = ^d;
      idx = 10;
    end
    f.bits[idx] = 1'b1;
    f.nbits     = idx + 1;
    f.div       = div_of(k);
    f.start     = e;
    qpush(k, f);
  endtask

  // Reference model: a LOAD is taken once the previous frame plus one idle cycle has passed.
  initial begin
    cyc = 0;
    for (int k = 0; k < 3; k++) next_ok[k] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!rstn[k]) begin
          next_ok[k] = 0;
          qclear(k);
        end else if (load[k] && cyc >= next_ok[k]) begin
          model_accept(k, data_of(k), cyc);
          next_ok[k] = cyc + frame_len(k) + 1;
        end
      end
    end
  end

  // Monitor: on each start bit pop the expected frame and follow it cycle by cycle.
  task automatic mon(input int k);
    frame_t f;
    int     n;
    bit     ab;
    int     guard;
    logic   eb;
    logic   nb;
    forever begin
      @(negedge clk);
      if (rstn[k]) begin
        if (sdo[k] === 1'b1) begin
          chk("idle_sdon", k, 32'(sdon[k]), 32'd0);
          chk("idle_done", k, 32'(done[k]), 32'd0);
          chk("idle_ready", k, 32'(ready[k]), 32'd1);
        end else if (qsize(k) == 0) begin
          chk("unexpected_frame", k, 32'(sdo[k]), 32'd1);
          guard = 0;
          while (sdo[k] !== 1'b1 && rstn[k] && guard < 200) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          qpop(k, f);
          n  = f.nbits * f.div;
          ab = 1'b0;
          chk("start_cycle", k, 32'(cyc), 32'(f.start));
          for (int c = 0; c < n && !ab; c++) begin
            if (c > 0) @(negedge clk);
            if (!rstn[k]) begin
              ab = 1'b1;
            end else begin
              eb = f.bits[c / f.div];
              nb = ~eb;
              chk("line_bit", k, 32'(sdo[k]), 32'(eb));
              chk("line_bit_n", k, 32'(sdon[k]), 32'(nb));
              chk("frame_busy", k, 32'(busy[k]), 32'd1);
              chk("frame_ready", k, 32'(ready[k]), 32'd0);
              chk("frame_done", k, 32'(done[k]), 32'd0);
            end
          end
          if (!ab) begin
            @(negedge clk);
            if (rstn[k]) begin
              chk("end_done", k, 32'(done[k]), 32'd1);
              chk("end_ready", k, 32'(ready[k]), 32'd1);
              chk("end_busy", k, 32'(busy[k]), 32'd0);
              chk("end_sdo", k, 32'(sdo[k]), 32'd1);
              chk("end_sdon", k, 32'(sdon[k]), 32'd0);
            end
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic set_data(input int k, input logic [7:0] d);
    if (k == 0) data0 = d;
    else if (k == 1) data1 = d;
    else data2 = d;
  endtask

  // Inputs change 2ns after a rising edge.
  task automatic send(input int k, input logic [7:0] d);
    @(posedge clk);
    #2;
    set_data(k, d);
    load[k] = 1'b1;
    @(posedge clk);
    #2;
    load[k] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk_idle_outputs(input string name, input int k);
    chk({name, "_sdo"}, k, 32'(sdo[k]), 32'd1);
    chk({name, "_sdon"}, k, 32'(sdon[k]), 32'd0);
    chk({name, "_ready"}, k, 32'(ready[k]), 32'd1);
    chk({name, "_busy"}, k, 32'(busy[k]), 32'd0);
    chk({name, "_done"}, k, 32'(done[k]), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 3'b111;
    load  = 3'b000;
    data0 = 8'h00;
    data1 = 8'h00;
    data2 = 8'h00;
    #1;
    rstn = 3'b000;
    wait_cycles(3);
    #2;
    for (int k = 0; k < 3; k++) chk_idle_outputs("in_reset", k);
    rstn = 3'b111;
    #1;
    for (int k = 0; k < 3; k++) chk_idle_outputs("after_reset", k);

    // Basic frame with a rejected LOAD of FF at accept+10.
    send(0, 8'hA5);
    wait_cycles(9);
    #2;
    data0   = 8'hFF;
    load[0] = 1'b1;
    @(posedge clk);
    #2;
    load[0] = 1'b0;
    wait_cycles(40);

    // Odd parity word with and without the parity slot.
    send(0, 8'h07);
    send(1, 8'h07);
    wait_cycles(50);

    // LOAD held high: second frame one idle cycle after the first.
    @(posedge clk);
    #2;
    data0   = 8'h3C;
    load[0] = 1'b1;
    wait_cycles(60);
    #2;
    load[0] = 1'b0;
    wait_cycles(40);

    // Mid-frame reset, then fresh frames.
    send(0, 8'h96);
    wait_cycles(18);
    #2;
    rstn[0] = 1'b0;
    #1;
    chk_idle_outputs("async_reset", 0);
    wait_cycles(2);
    #2;
    rstn[0] = 1'b1;
    wait_cycles(6);
    send(2, 8'h5A);
    send(0, 8'h5A);
    wait_cycles(50);

    // Random LOAD pulses and DATA churn on all three instances.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        load[k] = ($urandom_range(0, 3) == 0);
        set_data(k, 8'($urandom));
      end
    end
    @(posedge clk);
    #2;
    load = 3'b000;
    wait_cycles(60);

    for (int k = 0; k < 3; k++) chk("queue_drained", k, 32'(qsize(k)), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
